regfile_param: RTL and testbench

- Parametrised successor to the single-cycle processor's 32x32 register file: 2 asynchronous read ports, 1 synchronous write port.
- Adds configurable width/depth, byte-enable writes, optional hardwired-zero entry, optional write-to-read bypass, and a sequenced clear engine.
- The clear engine runs after reset and on request, replacing simulation-only initialisation.
- Sits between instruction decode (read addresses) and writeback (write port) in the datapath.

---
 rtl/regfile_param.sv | 144 ++++++++++++++
 tb/tb_regfile_param.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2R/1W register file with byte enables, bypass and clear engine
//
// Two combinational read ports and one synchronous byte-enabled write port.
// After reset, and on clr_req, a clear engine walks every entry and writes
// zero. While it runs, writes are refused and reads return zero.

module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [ADDR_W-1:0]   rd_addr1,
  output logic [DATA_W-1:0]   rd_data1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data2,
  input  logic                clr_req,
  output logic                busy,
  output logic                wr_drop
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] be_mask;
  logic              wr_zero;
  logic              wr_ok;

  // Byte-wise merge: new bytes where the mask is set, old bytes elsewhere.
  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [DATA_W-1:0] mask
  );
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign busy    = (state == CLEAR);
  assign wr_zero = ZERO_REG && (wr_addr == '0);
  // A write that actually lands in the array (and may be forwarded).
  assign wr_ok   = wr_en && !busy && !wr_zero;

  // Expand byte enables into a bit mask.
  always_comb begin
    be_mask = '0;
    for (int k = 0; k < NBYTES; k++) begin
      be_mask[8*k +: 8] = {8{wr_be[k]}};
    end
  end

  // Clear-engine state register; reset restarts the clear from entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end

  // Next-state logic: walk all entries once, then idle until clr_req.
  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_nx = clr_ptr + ADDR_W'(1);
        if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
          state_nx = IDLE;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_nx   = CLEAR;
          clr_ptr_nx = '0;
        end
      end
      default: begin
        state_nx   = CLEAR;
        clr_ptr_nx = '0;
      end
    endcase
  end

  // One-cycle pulse flagging a write refused because the clear was running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && busy;
    end
  end

  // Array update: clear engine has priority; during reset busy is high, so
  // no user write can land and the engine only rewrites entry 0 with zero.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= merge(mem[wr_addr], wr_data, be_mask);
    end
  end

  // Read port 1: optional forwarding of the write in flight, zero when busy
  // or addressing the hardwired-zero entry.
  always_comb begin
    rd_data1 = mem[rd_addr1];
    if (BYPASS && wr_ok && (wr_addr == rd_addr1)) begin
      rd_data1 = merge(mem[rd_addr1], wr_data, be_mask);
    end
    if (busy || (ZERO_REG && (rd_addr1 == '0))) begin
      rd_data1 = '0;
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rd_data2 = mem[rd_addr2];
    if (BYPASS && wr_ok && (wr_addr == rd_addr2)) begin
      rd_data2 = merge(mem[rd_addr2], wr_data, be_mask);
    end
    if (busy || (ZERO_REG && (rd_addr2 == '0))) begin
      rd_data2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed-vector bench for regfile_param

module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        clr_req;

  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        busy, busy_nb, drop, drop_nb;

  int vectors;
  int miscompares;
  int cnt;
  int bad;

  // Default build: ZERO_REG=1, BYPASS=1.
  regfile_param dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd1),
    .rd_addr2 (rd_addr2),
    .rd_data2 (rd2),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_drop  (drop)
  );

  // Alternate build: ZERO_REG=0, BYPASS=0, same stimulus.
  regfile_param #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .ZERO_REG (1'b0),
    .BYPASS   (1'b0)
  ) dut_nb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd1_nb),
    .rd_addr2 (rd_addr2),
    .rd_data2 (rd2_nb),
    .clr_req  (clr_req),
    .busy     (busy_nb),
    .wr_drop  (drop_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
    @(negedge clk);
    wr_en   = 1'b0;
    wr_be   = 4'b0000;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(a);
      #1;
      check($sformatf("%s_rd1[%0d]", tag, a), rd1, 32'h0);
      check($sformatf("%s_nb_rd2[%0d]", tag, a), rd2_nb, 32'h0);
      @(negedge clk);
    end
  endtask

  // Counts busy cycles starting at the current negedge, stepping one cycle at a time.
  task automatic count_busy(output int n, output int nonzero);
    n = 0;
    nonzero = 0;
    while (busy && n < 100) begin
      n++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0 || rd1_nb !== 32'h0 || rd2_nb !== 32'h0) nonzero++;
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 32'h0;
    wr_be    = 4'b0000;
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd31;
    clr_req  = 1'b0;

    // Held in reset, with a write attempt that must not raise wr_drop.
    repeat (2) @(negedge clk);
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("rst_busy", busy, 1);
    check("rst_drop", drop, 0);
    check("rst_rd1", rd1, 32'h0);

    // Initial clear after reset release.
    @(negedge clk);
    rst = 1'b1;
    count_busy(cnt, bad);
    check("init_busy_cycles", cnt, 32);
    check("init_rd_zero_while_busy", bad, 0);
    check("init_nb_busy", busy_nb, 0);
    check_all_zero("init");

    // Byte-enable write.
    do_write(5'd5, 32'hDEADBEEF, 4'b1111);
    do_write(5'd5, 32'h11223344, 4'b0101);
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd5;
    #1;
    check("be_rd1", rd1, 32'hDE22BE44);
    check("be_nb_rd2", rd2_nb, 32'hDE22BE44);
    check("be_drop", drop, 0);
    @(negedge clk);

    // Same-cycle forwarding on both ports vs. pre-write contents.
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd7;
    wr_en    = 1'b1;
    wr_addr  = 5'd7;
    wr_data  = 32'hCAFEF00D;
    wr_be    = 4'b1111;
    #1;
    check("byp_rd1", rd1, 32'hCAFEF00D);
    check("byp_rd2", rd2, 32'hCAFEF00D);
    check("nobyp_rd1_old", rd1_nb, 32'h0);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("nobyp_rd1_next", rd1_nb, 32'hCAFEF00D);
    @(negedge clk);

    // Partial-byte forwarding merges with stored bytes.
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h12345678;
    wr_be   = 4'b0011;
    #1;
    check("byp_merge_rd1", rd1, 32'hCAFE5678);
    check("nobyp_merge_old", rd1_nb, 32'hCAFEF00D);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("nobyp_merge_next", rd1_nb, 32'hCAFE5678);
    @(negedge clk);

    // All-zero byte enables change nothing.
    do_write(5'd7, 32'h00000000, 4'b0000);
    #1;
    check("be_zero_rd1", rd1, 32'hCAFE5678);
    @(negedge clk);

    // Hardwired zero entry vs. ordinary entry 0.
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd0;
    wr_en    = 1'b1;
    wr_addr  = 5'd0;
    wr_data  = 32'hFFFFFFFF;
    wr_be    = 4'b1111;
    #1;
    check("zero_byp_rd1", rd1, 32'h0);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("zero_rd1", rd1, 32'h0);
    check("zero_rd2", rd2, 32'h0);
    check("zero_drop", drop, 0);
    check("nozero_rd1", rd1_nb, 32'hFFFFFFFF);
    check("nozero_rd2", rd2_nb, 32'hFFFFFFFF);
    @(negedge clk);

    // Fill, then clear on request with a concurrent write to addr 3.
    for (int a = 1; a < 32; a++) do_write(5'(a), 32'hA5000000 | 32'(a), 4'b1111);
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd31;
    #1;
    check("fill_rd1", rd1, 32'hA5000003);
    check("fill_rd2", rd2, 32'hA500001F);
    @(negedge clk);
    clr_req = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h33333333;
    wr_be   = 4'b1111;
    @(negedge clk);
    clr_req = 1'b0;
    wr_en   = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      #1;
      case (cnt)
        1: check("clr_req_write_no_drop", drop, 0);
        2: begin
          wr_en   = 1'b1;
          wr_addr = 5'd9;
          wr_data = 32'h99999999;
          wr_be   = 4'b1111;
        end
        3: begin
          wr_en = 1'b0;
          check("busy_write_drop", drop, 1);
          check("busy_write_drop_nb", drop_nb, 1);
        end
        4: check("drop_one_cycle", drop, 0);
        5: begin
          check("busy_rd1_zero", rd1, 32'h0);
          check("busy_rd2_zero", rd2, 32'h0);
        end
        10: clr_req = 1'b1;
        11: clr_req = 1'b0;
        default: ;
      endcase
      @(negedge clk);
    end
    check("clr_busy_cycles", cnt, 32);
    check_all_zero("clr");

    // Reset at clear cycle 10 with a write pending; clear restarts in full.
    for (int a = 1; a < 32; a++) do_write(5'(a), 32'h5A000000 | 32'(a), 4'b1111);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (9) @(negedge clk);
    rst     = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd20;
    wr_data = 32'hFFFFFFFF;
    wr_be   = 4'b1111;
    #1;
    check("midclr_rst_busy0", busy, 1);
    @(negedge clk);
    check("midclr_rst_busy1", busy, 1);
    check("midclr_rst_drop1", drop, 0);
    @(negedge clk);
    check("midclr_rst_busy2", busy, 1);
    check("midclr_rst_drop2", drop, 0);
    rst   = 1'b1;
    wr_en = 1'b0;
    count_busy(cnt, bad);
    check("midclr_busy_cycles", cnt, 32);
    check("midclr_rd_zero_while_busy", bad, 0);
    check_all_zero("midclr");

    // Asynchronous reset from IDLE raises busy without a clock edge.
    rst = 1'b0;
    #1;
    check("async_rst_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    count_busy(cnt, bad);
    check("async_busy_cycles", cnt, 32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
